// File: rtl/mux_nto1_pipe.sv
// Registered N-to-1 channel multiplexer with valid/ready on every input and on the output.
// Define MUX_NTO1_RR_EN to compile in the round-robin arbiter; otherwise mode_i is ignored.
module mux_nto1_pipe #(
  parameter int size  = 32,
  parameter int sel_w = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [(2**sel_w)*size-1:0]  data_i,
  input  logic [(2**sel_w)-1:0]       valid_i,
  output logic [(2**sel_w)-1:0]       ready_o,
  input  logic [sel_w-1:0]            select_i,
  input  logic                        mode_i,
  output logic [size-1:0]             data_o,
  output logic [sel_w-1:0]            chan_o,
  output logic                        valid_o,
  input  logic                        ready_i
);

  localparam int ch = 2**sel_w;

  logic             grant;
  logic [sel_w-1:0] grant_idx;
  logic             space;
  logic             load;

`ifdef MUX_NTO1_RR_EN
  logic [sel_w-1:0] ptr;
  logic             rr_grant;
  logic [sel_w-1:0] rr_idx;
  logic [sel_w-1:0] scan_idx;

  // Scan from ptr upward; sel_w-bit addition wraps ch-1 back to 0 for free.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    rr_grant = 1'b0;
    rr_idx   = ptr;
    scan_idx = ptr;
    for (int i = 0; i < ch; i++) begin
      scan_idx = ptr + sel_w'(i);
      if (!rr_grant && valid_i[scan_idx]) begin
        rr_grant = 1'b1;
        rr_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    if (mode_i) begin
      grant     = rr_grant;
      grant_idx = rr_idx;
    end else begin
      grant     = valid_i[select_i];
      grant_idx = select_i;
    end
  end

  // ptr only advances on an RR grant, so it survives select-mode stretches untouched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr <= '0;
    end else if (load && mode_i) begin
      ptr <= grant_idx + sel_w'(1);
    end
  end
`else
  logic mode_unused;
  assign mode_unused = mode_i;

  always_comb begin
    grant     = valid_i[select_i];
    grant_idx = select_i;
  end
`endif

  // Reset gates load so no producer sees an accept while the register is being cleared.
  assign space = ~valid_o | ready_i;
  assign load  = grant & space & ~rst_i;

  always_comb begin
    ready_o = '0;
    if (load) begin
      ready_o[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    if (rst_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      chan_o  <= '0;
    end else if (load) begin
      valid_o <= 1'b1;
      data_o  <= data_i[int'(grant_idx)*size +: size];
      chan_o  <= grant_idx;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: doc/mux_nto1_pipe.md
# mux_nto1_pipe

Parametrised, registered N-to-1 channel multiplexer with a valid/ready handshake on every input and on the output, for pipeline-stage data selection and for merging multiple producers. A `2**sel_w`-input selector feeds a single output register stage. Each cycle exactly one channel is granted, either by an explicit select or by a round-robin arbiter. Throughput is one word per cycle and latency is one cycle.

## Interface
Parameters:
- `size`, 32, data width per channel (≥1).
- `sel_w`, 2, select width; channel count `ch = 2**sel_w` (`sel_w` 1..4).

Ports:
- `clk_i`, input, 1, single clock; all state updates on the rising edge.
- `rst_i`, input, 1, reset; synchronous, active-high.
- `data_i`, input, `ch*size`, channel k occupies bits `[k*size +: size]`.
- `valid_i`, input, `ch`, per-channel valid.
- `ready_o`, output, `ch`, per-channel accept; at most one bit set.
- `select_i`, input, `sel_w`, channel index used in select mode.
- `mode_i`, input, 1, 0 = select mode, 1 = round-robin mode.
- `data_o`, output, `size`, registered selected word.
- `chan_o`, output, `sel_w`, index of the channel that supplied `data_o`.
- `valid_o`, output, 1, output register holds a word.
- `ready_i`, input, 1, downstream accept.

## Operation
- Internal state:
  - output register `data_o`/`chan_o`/`valid_o`;
  - round-robin pointer `ptr` (`sel_w` bits), which is the highest-priority channel for the next RR grant.
- Grant (combinational, every cycle):
  - Select mode: grant `select_i` if `valid_i[select_i]`, else no grant. Other channels are never granted.
  - RR mode: grant the first k with `valid_i[k]=1`, scanning `ptr, ptr+1, …` modulo `ch`. No grant if `valid_i==0`.
- `space = ~valid_o | ready_i`.
- `load = grant & space`.
- `ready_o[g] = load` for granted channel g. All other `ready_o` bits are 0.
- A transfer on channel k happens when `valid_i[k] & ready_o[k]`. A transfer on the output happens when `valid_o & ready_i`.
- On `load`:
  - `data_o <= data_i[g]`, `chan_o <= g`, `valid_o <= 1`.
  - In RR mode, `ptr <= g+1` (wraps `ch-1 → 0`).
  - In select mode, `ptr` is unchanged.
- If no `load` and `ready_i` is high: `valid_o <= 0`. `data_o` and `chan_o` hold their last values.
- If no `load` and `ready_i` is low: all outputs hold.
- Stall: while `valid_o & ~ready_i`, the output register, `data_o` and `chan_o` are stable and every `ready_o` bit is 0.
- A `mode_i` or `select_i` change takes effect in the same cycle's grant. `ptr` is retained across mode switches.
- `ready_o` depends combinationally on `valid_i`, `select_i`, `mode_i` and `ready_i`. Producers must not make `valid_i` depend on `ready_o`.
- Producers must hold `valid_i` and data until accepted. The block does not check this.

## Timing
- Reset (`rst_i` high at an edge): `valid_o=0`, `data_o=0`, `chan_o=0`, `ptr=0`. `ready_o` is 0 during the reset cycle.
- Reset mid-operation drops any held word with no output transfer; the source handshake for that word has already completed.
- Latency: input transfer at edge N gives `valid_o=1` with that word after edge N.
- Back-to-back operation: with `ready_i=1` continuously and a granted channel every cycle, one word moves per cycle with no bubble.
- Simultaneous output drain and load in the same cycle: the old word leaves and the new word replaces it; `valid_o` stays 1.
- RR fairness: with all channels valid continuously and `ready_i=1`, grants are 0,1,…,ch-1,0,… from reset. Each channel waits at most `ch-1` grants.

## Configuration
- `MUX_NTO1_RR_EN` defined:
  - round-robin arbiter and `ptr` are compiled in;
  - `mode_i` is honoured as described.
- `MUX_NTO1_RR_EN` undefined:
  - no `ptr` register and no arbiter;
  - `mode_i` is ignored and the block always operates in select mode;
  - all other behaviour is unchanged.

## Test plan
- Reset: assert `rst_i` for 2 cycles with all inputs valid -> `valid_o=0`, `data_o=0`, `chan_o=0`, `ready_o=0`; first grant after release in RR mode is channel 0.
- Select mode, `size=32`, `sel_w=2`: `select_i=2`, `valid_i=4'b1111`, data k = `32'hA0+k`, `ready_i=1` -> `ready_o=4'b0100`, next cycle `data_o=32'hA2`, `chan_o=2`; `valid_i[2]=0` -> no grant, `valid_o` falls after one cycle.
- RR sequence: `mode_i=1`, `valid_i=4'b1011` held, `ready_i=1` -> `chan_o` sequence 0,1,3,0,1,3 with `valid_o` continuously 1.
- Backpressure: output loaded with `32'h55`, then `ready_i=0` for 3 cycles with `valid_i=4'b0001` -> `ready_o=0` and `data_o=32'h55` stable; on `ready_i=1`, channel 0 is accepted the same cycle and the new word appears the next cycle.
- Mid-stream reset: `valid_o=1` and `ptr=2`, pulse `rst_i` -> `valid_o=0`, and the next RR grant with `valid_i=4'b1111` is channel 0.
- Build without `MUX_NTO1_RR_EN`: `mode_i=1`, `select_i=1`, `valid_i=4'b1111` -> only channel 1 is ever granted.
